// File: rtl/eei_pkg.sv
// rtl/eei_pkg.sv - shared memory-bus widths, address type and arbiter state encoding
// Purpose: common definitions for the core-side memory bus.
// Contents: MEMBUS_DATA_WIDTH, MEMBUS_MASK_WIDTH, ADDR_WIDTH, Addr, MembusArbState.
package eei;
   localparam int MEMBUS_DATA_WIDTH = 64;
   localparam int MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH / 8;
   localparam int ADDR_WIDTH        = 64;

   typedef logic [ADDR_WIDTH-1:0] Addr;

   // State names the owner of the single outstanding downstream transaction.
   typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_IF, ARB_WAIT_D} MembusArbState;
endpackage

// File: rtl/membus_arb_starve_ctr.sv
// rtl/membus_arb_starve_ctr.sv - fetch starvation counter for the memory-bus arbiter
// Purpose: counts data grants taken while fetch is waiting; flags when the limit is reached.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   if_valid_i      fetch is requesting
//   d_hs_i          data handshake downstream this cycle
//   if_hs_i         fetch handshake downstream this cycle
//   starved_o       count has reached STARVE_LIMIT; fetch must win the next issue window
module membus_arb_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic if_valid_i,
   input  logic d_hs_i,
   input  logic if_hs_i,
   output logic starved_o
);
   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (if_hs_i || !if_valid_i) begin
         count_d = 4'd0;
      end else if (d_hs_i && count_q != 4'hF) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign starved_o = (count_q == 4'(STARVE_LIMIT));
endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - fetch/data arbiter for the single shared memory bus
// Purpose: one outstanding downstream transaction, data priority, responses routed to issuer.
// Optional: define MEMBUS_ARBITER_FAIR_EN to force fetch through after STARVE_LIMIT
//           consecutive data grants while fetch waits.
// Ports:
//   i_clk, i_rst                           clock, synchronous active-high reset
//   if_valid/if_ready/if_addr              fetch request
//   if_rvalid/if_rdata                     fetch response
//   d_valid/d_ready/d_addr/d_wen/d_wdata/d_wmask   data request
//   d_rvalid/d_rdata                       data response
//   mem_valid/mem_ready/mem_addr/mem_wen/mem_wdata/mem_wmask  downstream request
//   mem_rvalid/mem_rdata                   downstream response
module membus_arbiter
   import eei::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         if_valid,
   output logic                         if_ready,
   input  logic [ADDR_WIDTH-1:0]        if_addr,
   output logic                         if_rvalid,
   output logic [MEMBUS_DATA_WIDTH-1:0] if_rdata,
   input  logic                         d_valid,
   output logic                         d_ready,
   input  logic [ADDR_WIDTH-1:0]        d_addr,
   input  logic                         d_wen,
   input  logic [MEMBUS_DATA_WIDTH-1:0] d_wdata,
   input  logic [MEMBUS_MASK_WIDTH-1:0] d_wmask,
   output logic                         d_rvalid,
   output logic [MEMBUS_DATA_WIDTH-1:0] d_rdata,
   output logic                         mem_valid,
   input  logic                         mem_ready,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic                         mem_wen,
   output logic [MEMBUS_DATA_WIDTH-1:0] mem_wdata,
   output logic [MEMBUS_MASK_WIDTH-1:0] mem_wmask,
   input  logic                         mem_rvalid,
   input  logic [MEMBUS_DATA_WIDTH-1:0] mem_rdata
);
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("membus_arbiter: STARVE_LIMIT must be in 1..15");
   end

   MembusArbState state_q, state_d;
   logic          can_issue;
   logic          force_if;
   logic          grant_d;
   logic          grant_if;
   logic          mem_hs;

   // A response retiring in this cycle frees the bus for a same-cycle issue.
   assign can_issue = (state_q == ARB_IDLE) | mem_rvalid;

   assign grant_d  = can_issue & d_valid & ~force_if;
   assign grant_if = can_issue & if_valid & ~grant_d;

   // Every output is held at zero while reset is asserted.
   always_comb begin
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wen   = 1'b0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (!i_rst) begin
         mem_valid = grant_d | grant_if;
         if (grant_d) begin
            mem_addr  = d_addr;
            mem_wen   = d_wen;
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
         end else if (grant_if) begin
            mem_addr  = if_addr;
         end
      end
   end

   assign mem_hs   = mem_valid & mem_ready;
   assign d_ready  = grant_d & mem_hs;
   assign if_ready = grant_if & mem_hs;

   // State already reflects who owns the returning response, even when a new
   // request is issued in the same cycle; a response in IDLE goes nowhere.
   assign if_rvalid = ~i_rst & mem_rvalid & (state_q == ARB_WAIT_IF);
   assign d_rvalid  = ~i_rst & mem_rvalid & (state_q == ARB_WAIT_D);
   assign if_rdata  = i_rst ? '0 : mem_rdata;
   assign d_rdata   = i_rst ? '0 : mem_rdata;

`ifdef MEMBUS_ARBITER_FAIR_EN
   logic starved;

   membus_arb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .if_valid_i (if_valid),
      .d_hs_i     (d_ready),
      .if_hs_i    (if_ready),
      .starved_o  (starved)
   );

   assign force_if = starved & if_valid;
`else
   assign force_if = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (mem_hs) begin
         state_d = grant_d ? ARB_WAIT_D : ARB_WAIT_IF;
      end else if (mem_rvalid) begin
         state_d = ARB_IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end
endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - self-checking bench for membus_arbiter
module tb_membus_arbiter;
   localparam int LIMIT = 4;
`ifdef MEMBUS_ARBITER_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        if_valid, if_ready, if_rvalid;
   logic [63:0] if_addr, if_rdata;
   logic        d_valid, d_ready, d_wen, d_rvalid;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [7:0]  d_wmask;
   logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: who owns the outstanding transaction (0 none, 1 fetch, 2 data)
   // and how many data grants fetch has watched go by.
   int owner;
   int starve;
   bit e_gd, e_gi, e_mv;

   always #5 i_clk = ~i_clk;

   membus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
      .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic clear_inputs();
      if_valid = 0; if_addr = 0;
      d_valid = 0; d_addr = 0; d_wen = 0; d_wdata = 0; d_wmask = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      clear_inputs();
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      owner = 0;
      starve = 0;
   endtask

   // Grant decision from the current inputs and model state.
   task automatic model_grant();
      bit can, force_f;
      can = (owner == 0) || mem_rvalid;
      force_f = FAIR && (starve == LIMIT) && if_valid;
      e_gd = can && d_valid && !force_f;
      e_gi = can && if_valid && !e_gd;
      e_mv = e_gd || e_gi;
   endtask

   task automatic model_advance();
      bit hs;
      hs = e_mv && mem_ready;
      if (hs) owner = e_gd ? 2 : 1;
      else if (mem_rvalid) owner = 0;
      if ((hs && e_gi) || !if_valid) starve = 0;
      else if (hs && e_gd) starve++;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      if_valid = 1; if_addr = 64'h1234;
      d_valid = 1; d_addr = 64'h5678; d_wen = 1; d_wdata = 64'hFFFF_0000_FFFF_0000; d_wmask = 8'hFF;
      mem_ready = 1; mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      #1;
      n_checks++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got %b want 0", mem_valid); else n_pass++;
      n_checks++; if (if_ready !== 1'b0) $display("FAIL reset_if_ready got %b want 0", if_ready); else n_pass++;
      n_checks++; if (d_ready !== 1'b0) $display("FAIL reset_d_ready got %b want 0", d_ready); else n_pass++;
      n_checks++; if (if_rvalid !== 1'b0) $display("FAIL reset_if_rvalid got %b want 0", if_rvalid); else n_pass++;
      n_checks++; if (d_rvalid !== 1'b0) $display("FAIL reset_d_rvalid got %b want 0", d_rvalid); else n_pass++;
      n_checks++; if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) $display("FAIL reset_mem_payload got %h/%h/%h/%b want 0", mem_addr, mem_wdata, mem_wmask, mem_wen); else n_pass++;
      n_checks++; if ({if_rdata, d_rdata} !== '0) $display("FAIL reset_rdata got %h/%h want 0", if_rdata, d_rdata); else n_pass++;
      do_reset();
   endtask

   task automatic test_fetch_only();
      do_reset();
      if_valid = 1; if_addr = 64'h1000; mem_ready = 1;
      #1;
      n_checks++; if (mem_valid !== 1'b1) $display("FAIL fo_mem_valid got %b want 1", mem_valid); else n_pass++;
      n_checks++; if (mem_addr !== 64'h1000) $display("FAIL fo_mem_addr got %h want 1000", mem_addr); else n_pass++;
      n_checks++; if ({mem_wen, mem_wmask, mem_wdata} !== '0) $display("FAIL fo_wr_fields got %b/%h/%h want 0", mem_wen, mem_wmask, mem_wdata); else n_pass++;
      n_checks++; if (if_ready !== 1'b1) $display("FAIL fo_if_ready got %b want 1", if_ready); else n_pass++;
      @(negedge i_clk);
      if_valid = 0;
      #1;
      n_checks++; if (if_ready !== 1'b0 || mem_valid !== 1'b0) $display("FAIL fo_wait got ready=%b mem_valid=%b want 0/0", if_ready, mem_valid); else n_pass++;
      @(negedge i_clk);
      mem_rvalid = 1; mem_rdata = 64'h00000013_00000297;
      #1;
      n_checks++; if (if_rvalid !== 1'b1) $display("FAIL fo_if_rvalid got %b want 1", if_rvalid); else n_pass++;
      n_checks++; if (if_rdata !== 64'h00000013_00000297) $display("FAIL fo_if_rdata got %h want 0000001300000297", if_rdata); else n_pass++;
      n_checks++; if (d_rvalid !== 1'b0) $display("FAIL fo_d_rvalid got %b want 0", d_rvalid); else n_pass++;
      @(negedge i_clk);
      mem_rvalid = 0;
   endtask

   task automatic test_both_valid();
      do_reset();
      if_valid = 1; if_addr = 64'h2000;
      d_valid = 1; d_addr = 64'h8000_0010; d_wen = 1; d_wdata = 64'hA5A5_5A5A_0123_4567; d_wmask = 8'hFF;
      mem_ready = 1;
      #1;
      n_checks++; if (d_ready !== 1'b1 || if_ready !== 1'b0) $display("FAIL bv_grant got d=%b if=%b want 1/0", d_ready, if_ready); else n_pass++;
      n_checks++; if (mem_wen !== 1'b1 || mem_addr !== 64'h8000_0010 || mem_wmask !== 8'hFF || mem_wdata !== 64'hA5A5_5A5A_0123_4567)
         $display("FAIL bv_payload got %b/%h/%h/%h want 1/80000010/ff/a5a55a5a01234567", mem_wen, mem_addr, mem_wmask, mem_wdata); else n_pass++;
      @(negedge i_clk);
      d_valid = 0; d_wen = 0;
      #1;
      n_checks++; if (mem_valid !== 1'b0 || if_ready !== 1'b0) $display("FAIL bv_hold got mem_valid=%b if_ready=%b want 0/0", mem_valid, if_ready); else n_pass++;
      @(negedge i_clk);
      mem_rvalid = 1; mem_rdata = 64'h1;
      #1;
      n_checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) $display("FAIL bv_wr_resp got d=%b if=%b want 1/0", d_rvalid, if_rvalid); else n_pass++;
      n_checks++; if (if_ready !== 1'b1 || mem_addr !== 64'h2000 || mem_wen !== 1'b0) $display("FAIL bv_fetch_issue got ready=%b addr=%h wen=%b want 1/2000/0", if_ready, mem_addr, mem_wen); else n_pass++;
      @(negedge i_clk);
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      do_reset();
      d_valid = 1; d_addr = 64'h40; mem_ready = 1;
      @(negedge i_clk);
      d_valid = 0;
      if_valid = 1; if_addr = 64'h3000;
      mem_rvalid = 1; mem_rdata = 64'h77;
      #1;
      n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h77) $display("FAIL b2b_d_rvalid got %b/%h want 1/77", d_rvalid, d_rdata); else n_pass++;
      n_checks++; if (if_ready !== 1'b1 || mem_addr !== 64'h3000) $display("FAIL b2b_if_issue got %b/%h want 1/3000", if_ready, mem_addr); else n_pass++;
      @(negedge i_clk);
      if_valid = 0; mem_rdata = 64'h88;
      #1;
      n_checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL b2b_if_resp got if=%b d=%b want 1/0", if_rvalid, d_rvalid); else n_pass++;
      @(negedge i_clk);
      clear_inputs();
   endtask

   task automatic test_stall();
      do_reset();
      d_valid = 1; d_addr = 64'hC0DE_0008; d_wen = 1; d_wdata = 64'h55; d_wmask = 8'h0F;
      mem_ready = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (mem_valid !== 1'b1 || d_ready !== 1'b0) $display("FAIL stall_c%0d got mem_valid=%b d_ready=%b want 1/0", c, mem_valid, d_ready); else n_pass++;
         n_checks++; if (mem_addr !== 64'hC0DE_0008 || mem_wdata !== 64'h55 || mem_wmask !== 8'h0F) $display("FAIL stall_payload_c%0d got %h/%h/%h", c, mem_addr, mem_wdata, mem_wmask); else n_pass++;
         @(negedge i_clk);
      end
      mem_ready = 1;
      #1;
      n_checks++; if (d_ready !== 1'b1) $display("FAIL stall_release got d_ready=%b want 1", d_ready); else n_pass++;
      @(negedge i_clk);
      clear_inputs();
   endtask

   task automatic test_fairness();
      bit want_if;
      do_reset();
      if_valid = 1; if_addr = 64'h100; d_valid = 1; d_addr = 64'h200; mem_ready = 1;
      for (int k = 0; k < 12; k++) begin
         mem_rvalid = (k != 0);
         #1;
         want_if = FAIR && (k % (LIMIT + 1) == LIMIT);
         n_checks++; if (if_ready !== want_if || d_ready !== !want_if) $display("FAIL fair_grant_%0d got if=%b d=%b want if=%b", k, if_ready, d_ready, want_if); else n_pass++;
         @(negedge i_clk);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      d_valid = 1; d_addr = 64'h900; mem_ready = 1;
      @(negedge i_clk);
      i_rst = 1; mem_rvalid = 1; mem_rdata = 64'hFACE; if_valid = 1;
      #1;
      n_checks++; if ({mem_valid, if_ready, d_ready, if_rvalid, d_rvalid} !== 5'b0) $display("FAIL rm_ctrl got %b want 00000", {mem_valid, if_ready, d_ready, if_rvalid, d_rvalid}); else n_pass++;
      n_checks++; if ({mem_addr, d_rdata, if_rdata} !== '0) $display("FAIL rm_data got %h/%h/%h want 0", mem_addr, d_rdata, if_rdata); else n_pass++;
      @(negedge i_clk);
      i_rst = 0; d_valid = 0; if_valid = 0;
      #1;
      n_checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL rm_spurious got if=%b d=%b want 0/0", if_rvalid, d_rvalid); else n_pass++;
      @(negedge i_clk);
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (!if_valid && $urandom_range(0, 1)) begin
            if_valid = 1; if_addr = {32'h0, $urandom} & ~64'h7;
         end
         if (!d_valid && $urandom_range(0, 1)) begin
            d_valid = 1; d_addr = {$urandom, $urandom}; d_wen = 1'($urandom);
            d_wdata = {$urandom, $urandom}; d_wmask = 8'($urandom);
         end
         mem_ready = ($urandom_range(0, 9) < 7);
         mem_rvalid = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         mem_rdata = {$urandom, $urandom};
         model_grant();
         #1;
         n_checks++; if (mem_valid !== e_mv) $display("FAIL rnd_mem_valid c%0d got %b want %b", c, mem_valid, e_mv); else n_pass++;
         n_checks++; if (if_ready !== (e_gi && mem_ready) || d_ready !== (e_gd && mem_ready))
            $display("FAIL rnd_ready c%0d got if=%b d=%b want if=%b d=%b", c, if_ready, d_ready, e_gi && mem_ready, e_gd && mem_ready); else n_pass++;
         n_checks++; if (if_rvalid !== (mem_rvalid && owner == 1) || d_rvalid !== (mem_rvalid && owner == 2))
            $display("FAIL rnd_rvalid c%0d got if=%b d=%b owner=%0d", c, if_rvalid, d_rvalid, owner); else n_pass++;
         n_checks++; if (if_rdata !== mem_rdata || d_rdata !== mem_rdata) $display("FAIL rnd_rdata c%0d got %h/%h want %h", c, if_rdata, d_rdata, mem_rdata); else n_pass++;
         if (e_gd) begin
            n_checks++; if (mem_addr !== d_addr || mem_wen !== d_wen || mem_wdata !== d_wdata || mem_wmask !== d_wmask)
               $display("FAIL rnd_d_payload c%0d got %h/%b/%h/%h want %h/%b/%h/%h", c, mem_addr, mem_wen, mem_wdata, mem_wmask, d_addr, d_wen, d_wdata, d_wmask); else n_pass++;
         end else if (e_gi) begin
            n_checks++; if (mem_addr !== if_addr || mem_wen !== 1'b0 || mem_wdata !== 64'h0 || mem_wmask !== 8'h0)
               $display("FAIL rnd_if_payload c%0d got %h/%b/%h/%h want %h/0/0/0", c, mem_addr, mem_wen, mem_wdata, mem_wmask, if_addr); else n_pass++;
         end
         model_advance();
         @(negedge i_clk);
         if (e_gi && mem_ready) if_valid = 0;
         if (e_gd && mem_ready) d_valid = 0;
      end
      clear_inputs();
   endtask

   initial begin
      i_rst = 1'b1;
      clear_inputs();
      owner = 0;
      starve = 0;
      test_reset();
      test_fetch_only();
      test_both_valid();
      test_back_to_back();
      test_stall();
      test_fairness();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
